// File: rtl/mem_sequencer.sv
// Command sequencer driving a single-port synchronous RAM: WRITE, READ, FILL range, SUM range.
// Optional macro MEMSEQ_SUM_EN enables the SUM operation; without it op 11 completes with rsp_err.
module mem_sequencer (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_end,
  input  logic [15:0] cmd_data,
  output logic        ram_write,
  output logic [7:0]  ram_addr,
  output logic [15:0] ram_din,
  input  logic [15:0] ram_dout,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err
);

  typedef enum logic [2:0] {
    IDLE, WR, RD, RD_CAP, FILL, SUM, SUM_DRAIN, RSP
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_FILL  = 2'b10,
    OP_SUM   = 2'b11
  } op_t;

  state_t      state, state_next;
  logic        ram_write_next;
  logic [7:0]  ram_addr_next;
  logic [15:0] ram_din_next;
  logic        rsp_valid_next;
  logic [15:0] rsp_data_next;
  logic        rsp_err_next;
  logic [7:0]  range_end, range_end_next;
  logic [8:0]  fill_count, fill_count_next;
  logic        reject;
`ifdef MEMSEQ_SUM_EN
  logic [15:0] acc, acc_next;
  logic        sum_pending, sum_pending_next;
`endif

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state      <= IDLE;
      ram_write  <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      range_end  <= '0;
      fill_count <= '0;
`ifdef MEMSEQ_SUM_EN
      acc         <= '0;
      sum_pending <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      ram_write  <= ram_write_next;
      ram_addr   <= ram_addr_next;
      ram_din    <= ram_din_next;
      rsp_valid  <= rsp_valid_next;
      rsp_data   <= rsp_data_next;
      rsp_err    <= rsp_err_next;
      range_end  <= range_end_next;
      fill_count <= fill_count_next;
`ifdef MEMSEQ_SUM_EN
      acc         <= acc_next;
      sum_pending <= sum_pending_next;
`endif
    end
  end

  always_comb begin
    state_next      = state;
    ram_write_next  = 1'b0;
    ram_addr_next   = ram_addr;
    ram_din_next    = ram_din;
    rsp_valid_next  = 1'b0;
    rsp_data_next   = rsp_data;
    rsp_err_next    = rsp_err;
    range_end_next  = range_end;
    fill_count_next = fill_count;
    reject          = 1'b0;
`ifdef MEMSEQ_SUM_EN
    acc_next         = acc;
    sum_pending_next = sum_pending;
`endif

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          range_end_next = cmd_end;
          case (op_t'(cmd_op))
            OP_WRITE: begin
              state_next     = WR;
              ram_write_next = 1'b1;
              ram_addr_next  = cmd_addr;
              ram_din_next   = cmd_data;
            end
            OP_READ: begin
              state_next    = RD;
              ram_addr_next = cmd_addr;
            end
            OP_FILL: begin
              if (cmd_end < cmd_addr) begin
                reject = 1'b1;
              end else begin
                state_next      = FILL;
                ram_write_next  = 1'b1;
                ram_addr_next   = cmd_addr;
                ram_din_next    = cmd_data;
                fill_count_next = {1'b0, cmd_end} - {1'b0, cmd_addr} + 9'd1;
              end
            end
            OP_SUM: begin
`ifdef MEMSEQ_SUM_EN
              if (cmd_end < cmd_addr) begin
                reject = 1'b1;
              end else begin
                state_next       = SUM;
                ram_addr_next    = cmd_addr;
                acc_next         = '0;
                sum_pending_next = 1'b0;
              end
`else
              reject = 1'b1;
`endif
            end
            default: reject = 1'b1;
          endcase
        end
      end
      WR: begin
        state_next     = RSP;
        rsp_valid_next = 1'b1;
        rsp_data_next  = ram_din;
        rsp_err_next   = 1'b0;
      end
      RD: state_next = RD_CAP;
      RD_CAP: begin
        state_next     = RSP;
        rsp_valid_next = 1'b1;
        rsp_data_next  = ram_dout;
        rsp_err_next   = 1'b0;
      end
      FILL: begin
        // Stop on the last address rather than after it so 0..255 never wraps.
        if (ram_addr == range_end) begin
          state_next     = RSP;
          rsp_valid_next = 1'b1;
          rsp_data_next  = {7'b0, fill_count};
          rsp_err_next   = 1'b0;
        end else begin
          ram_write_next = 1'b1;
          ram_addr_next  = ram_addr + 8'd1;
        end
      end
`ifdef MEMSEQ_SUM_EN
      SUM: begin
        // ram_dout lags ram_addr by one cycle; the first SUM cycle has nothing to add yet.
        if (sum_pending) acc_next = acc + ram_dout;
        sum_pending_next = 1'b1;
        if (ram_addr == range_end) state_next = SUM_DRAIN;
        else ram_addr_next = ram_addr + 8'd1;
      end
      SUM_DRAIN: begin
        state_next     = RSP;
        rsp_valid_next = 1'b1;
        rsp_data_next  = acc + ram_dout;
        rsp_err_next   = 1'b0;
      end
`endif
      RSP: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (reject) begin
      state_next     = RSP;
      rsp_valid_next = 1'b1;
      rsp_data_next  = '0;
      rsp_err_next   = 1'b1;
    end
  end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named sysclk and reset.
REQ-002 Port list (name, direction, width, meaning):
- sysclk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_op  in  2  00 WRITE, 01 READ, 10 FILL, 11 SUM.
- cmd_addr  in  8  single address, or range start.
- cmd_end  in  8  range end, inclusive (FILL/SUM only).
- cmd_data  in  16  write/fill value.
- ram_write  out  1  RAM write strobe.
- ram_addr  out  8  RAM address.
- ram_din  out  16  RAM write data.
- ram_dout  in  16  RAM read data, valid one cycle after ram_addr is presented.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  16  result, held until the next rsp_valid.
- rsp_err  out  1  error flag, qualified by rsp_valid.

Function
REQ-003 States SHALL be IDLE, WR, RD, RD_CAP, FILL, SUM, SUM_DRAIN and RSP; cmd_ready=1 in IDLE only.
REQ-004 Fields SHALL be latched on acceptance; cmd_valid outside IDLE is ignored, not queued.
REQ-005 WRITE: accept edge k -> cycle k+1 in WR with ram_write=1, ram_addr=addr, ram_din=data -> cycle k+2 in RSP with rsp_data=data, rsp_err=0 -> IDLE.
REQ-006 READ: cycle k+1 in RD with ram_addr=addr, ram_write=0 -> cycle k+2 in RD_CAP, where ram_dout is captured -> cycle k+3 in RSP with rsp_data=captured word -> IDLE.
REQ-007 FILL with end>=start: ram_write=1 for exactly end-start+1 consecutive cycles; ram_addr steps start..end by +1; ram_din=data; then RSP with rsp_data = count zero-extended to 16 bits.
REQ-008 FILL with start=0 and end=255 SHALL write 256 words with no address wrap, and rsp_data SHALL be 0x0100.
REQ-009 SUM with end>=start: ram_addr steps start..end, one address per cycle, ram_write=0; each ram_dout is added one cycle after its address; SUM_DRAIN adds the last word; rsp_data = sum modulo 2^16.
REQ-010 FILL or SUM with end<start: no RAM access; the next cycle is RSP with rsp_err=1 and rsp_data=0.
REQ-011 rsp_valid SHALL be high for exactly one cycle per accepted command, in RSP; the next command can be accepted on the edge after RSP.
REQ-012 ram_write SHALL be 0 in every state other than WR and FILL.
REQ-013 ram_addr and ram_din SHALL hold their last values when idle.

Reset
REQ-014 While reset=1 at an edge, the block SHALL set: state=IDLE, ram_write=0, ram_addr=0, ram_din=0, rsp_valid=0, rsp_data=0, rsp_err=0, sum accumulator=0; cmd_ready reads 1.
REQ-015 Reset asserted mid-command SHALL abort the command with no rsp_valid, and ram_write SHALL be 0 from the next edge onward.

Configuration
REQ-016 The macro MEMSEQ_SUM_EN SHALL gate the SUM operation.
- Defined: SUM behaves per REQ-009.
- Undefined: SUM and SUM_DRAIN logic are absent; cmd_op=11 completes via RSP one cycle after acceptance with rsp_err=1, rsp_data=0, and no RAM access.

Verification
REQ-017 WRITE addr=0x12 data=0xBEEF, then READ 0x12 -> ram_write high for 1 cycle; READ rsp_data=0xBEEF with rsp_valid at k+3.
REQ-018 FILL start=0x10 end=0x13 data=0x5A5A -> 4 consecutive write cycles at 0x10..0x13; rsp_data=0x0004; READ 0x14 returns its prior value unchanged.
REQ-019 FILL 0..255 with 0x0001, then SUM 0..255 (MEMSEQ_SUM_EN defined) -> rsp_data=0x0100, rsp_err=0; FILL 0..255 with 0xFFFF, then SUM 0..1 -> rsp_data=0xFFFE.
REQ-020 FILL start=0x20 end=0x1F -> no ram_write; rsp_err=1, rsp_data=0; cmd_valid held during RSP is accepted on the following edge.
REQ-021 Reset asserted during the 3rd write cycle of FILL 0x00..0x0F -> ram_write=0 next cycle, no rsp_valid, cmd_ready=1; with MEMSEQ_SUM_EN undefined, cmd_op=11 -> rsp_err=1.
